// File: rtl/cic_interp.sv
// ---------------------------------------------------------------------------
// cic_interp
// Four-stage CIC interpolator. Low-rate samples enter through a single-entry
// buffer and pass through four comb stages. They are zero-stuffed by
// INTERPOLATION_RATIO and then integrated by four high-rate integrators.
// All arithmetic wraps modulo 2^REGISTER_WIDTH. The output is the last
// integrator, arithmetically shifted right by OUT_SHIFT and truncated.
//
// Ports
//   clk            : single clock
//   arst_n         : synchronous active-low reset
//   en             : high-rate clock enable; one output sample per en-high cycle
//   data_in        : signed low-rate input sample
//   data_in_valid  : data_in holds a valid sample
//   data_in_ready  : block accepts data_in this cycle
//   data_out       : signed high-rate output sample
//   data_out_valid : data_out updated this cycle
//   data_clk       : one-cycle pulse per input-sample consume event
//   underflow      : sticky; a consume event found the buffer empty
// ---------------------------------------------------------------------------
module cic_interp #(
  parameter int DATA_WIDTH_I        = 16,
  parameter int DATA_WIDTH_O        = 12,
  parameter int REGISTER_WIDTH      = 64,
  parameter int INTERPOLATION_RATIO = 8,
  parameter int OUT_SHIFT           = 13
) (
  input  logic                           clk,
  input  logic                           arst_n,
  input  logic                           en,
  input  logic signed [DATA_WIDTH_I-1:0] data_in,
  input  logic                           data_in_valid,
  output logic                           data_in_ready,
  output logic signed [DATA_WIDTH_O-1:0] data_out,
  output logic                           data_out_valid,
  output logic                           data_clk,
  output logic                           underflow
);

  localparam int PH_W = $clog2(INTERPOLATION_RATIO);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(INTERPOLATION_RATIO - 1);

  logic [PH_W-1:0]                   phase_q, phase_d;
  logic                              buf_vld_q;
  logic signed [DATA_WIDTH_I-1:0]    buf_q;
  logic signed [REGISTER_WIDTH-1:0]  cd1_q, cd2_q, cd3_q, cd4_q;
  logic signed [REGISTER_WIDTH-1:0]  zs_q;
  logic signed [REGISTER_WIDTH-1:0]  i1_q, i2_q, i3_q, i4_q;
  logic                              dov_q, dclk_q, unf_q;

  logic                              consume, xfer;
  logic signed [REGISTER_WIDTH-1:0]  x, c1, c2, c3, c4;

  always_comb begin
    consume       = en && (phase_q == '0);
    // A consume frees the slot in the same cycle, so a new sample may land.
    data_in_ready = !buf_vld_q || consume;
    xfer          = data_in_valid && data_in_ready;
    phase_d       = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
    // An empty buffer at consume time feeds zero into the combs.
    x  = buf_vld_q ? {{(REGISTER_WIDTH-DATA_WIDTH_I){buf_q[DATA_WIDTH_I-1]}}, buf_q}
                   : '0;
    c1 = x  - cd1_q;
    c2 = c1 - cd2_q;
    c3 = c2 - cd3_q;
    c4 = c3 - cd4_q;
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      phase_q   <= '0;
      buf_vld_q <= 1'b0;
      buf_q     <= '0;
      cd1_q     <= '0;
      cd2_q     <= '0;
      cd3_q     <= '0;
      cd4_q     <= '0;
      zs_q      <= '0;
      i1_q      <= '0;
      i2_q      <= '0;
      i3_q      <= '0;
      i4_q      <= '0;
      dov_q     <= 1'b0;
      dclk_q    <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      // Input buffer: a refill in the same cycle as a consume keeps it full.
      if (xfer) begin
        buf_q     <= data_in;
        buf_vld_q <= 1'b1;
      end else if (consume) begin
        buf_vld_q <= 1'b0;
      end

      // Low-rate comb delays advance only on consume events.
      if (consume) begin
        cd1_q <= x;
        cd2_q <= c1;
        cd3_q <= c2;
        cd4_q <= c3;
        if (!buf_vld_q) unf_q <= 1'b1;
      end

      // High-rate section: zero-stuffing and integrators, frozen while en is low.
      if (en) begin
        phase_q <= phase_d;
        zs_q    <= consume ? c4 : '0;
        i1_q    <= i1_q + zs_q;
        i2_q    <= i2_q + i1_q;
        i3_q    <= i3_q + i2_q;
        i4_q    <= i4_q + i3_q;
      end

      dov_q  <= en;
      dclk_q <= consume;
    end
  end

  assign data_out       = DATA_WIDTH_O'(i4_q >>> OUT_SHIFT);
  assign data_out_valid = dov_q;
  assign data_clk       = dclk_q;
  assign underflow      = unf_q;

endmodule

// File: tb/tb_cic_interp.sv
// ---------------------------------------------------------------------------
// tb_cic_interp
// Directed bench for cic_interp at default parameters. The impulse input is
// 8192, so that after the >>>13 output shift data_out equals the raw integer
// impulse response C(k-1,3) - 4*C(k-9,3) ...
// ---------------------------------------------------------------------------
module tb_cic_interp;

  logic               clk = 1'b0;
  logic               arst_n;
  logic               en;
  logic signed [15:0] data_in;
  logic               data_in_valid;
  logic               data_in_ready;
  logic signed [11:0] data_out;
  logic               data_out_valid;
  logic               data_clk;
  logic               underflow;

  int n_assert = 0;
  int n_fail   = 0;

  // I4 >>> 13 after the k-th en-high edge, counting the consume edge of an
  // 8192 impulse as k = 0.
  int imp_exp [13] = '{0, 0, 0, 0, 1, 4, 10, 20, 35, 56, 84, 120, 161};

  cic_interp dut (
    .clk            (clk),
    .arst_n         (arst_n),
    .en             (en),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_clk       (data_clk),
    .underflow      (underflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    step();
    step();
    arst_n = 1'b1;
  endtask

  initial begin
    int cnt;
    arst_n        = 1'b0;
    en            = 1'b0;
    data_in       = '0;
    data_in_valid = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_data_out",  data_out,       0);
    chk("rst_ready",     data_in_ready,  1);
    chk("rst_underflow", underflow,      0);
    chk("rst_dov",       data_out_valid, 0);
    chk("rst_dclk",      data_clk,       0);

    // Impulse: preload 8192 with en low, then run with zeros
    arst_n        = 1'b1;
    data_in       = 16'sd8192;
    data_in_valid = 1'b1;
    step();
    chk("preload_ready", data_in_ready, 0);
    en      = 1'b1;
    data_in = '0;
    for (int k = 0; k <= 12; k++) begin
      step();
      chk($sformatf("imp_out_k%0d", k), data_out, imp_exp[k]);
      chk($sformatf("imp_dclk_k%0d", k), data_clk, (k % 8 == 0) ? 1 : 0);
      chk($sformatf("imp_dov_k%0d", k), data_out_valid, 1);
    end
    chk("imp_underflow", underflow, 0);

    // Reset mid-period: phase counter is 5, integrators are nonzero, en and
    // the handshake are both active during the reset edge.
    arst_n = 1'b0;
    step();
    chk("midrst_data_out",  data_out,       0);
    chk("midrst_ready",     data_in_ready,  1);
    chk("midrst_underflow", underflow,      0);
    chk("midrst_dov",       data_out_valid, 0);
    chk("midrst_dclk",      data_clk,       0);

    // Underflow: no sample retained across reset, none offered afterwards
    arst_n        = 1'b1;
    data_in_valid = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      step();
      chk($sformatf("unf_flag_k%0d", k), underflow, 1);
      chk($sformatf("unf_dclk_k%0d", k), data_clk, (k % 8 == 0) ? 1 : 0);
      chk($sformatf("unf_out_k%0d", k), data_out, 0);
    end
    en = 1'b0;
    do_reset();
    chk("unf_cleared", underflow, 0);

    // DC: x = 1000 -> 512000 >>> 13 = 62
    data_in       = 16'sd1000;
    data_in_valid = 1'b1;
    step();
    en = 1'b1;
    for (int k = 0; k < 48; k++) begin
      step();
      if (k >= 32) chk($sformatf("dc_out_k%0d", k), data_out, 62);
    end
    chk("dc_underflow", underflow, 0);
    en = 1'b0;
    do_reset();

    // Full scale: x = 32767 -> 16776704 >>> 13 = 2047
    data_in       = 16'sd32767;
    data_in_valid = 1'b1;
    step();
    en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (k >= 32) chk($sformatf("fs_out_k%0d", k), data_out, 2047);
    end
    chk("fs_underflow", underflow, 0);
    en = 1'b0;
    do_reset();

    // en gating: 1010... must reproduce the en-continuous impulse sequence
    data_in       = 16'sd8192;
    data_in_valid = 1'b1;
    step();
    data_in = '0;
    cnt     = 0;
    for (int i = 0; i < 24; i++) begin
      logic exp_dclk;
      en       = (i % 2 == 0);
      exp_dclk = en && (cnt % 8 == 0);
      if (en) cnt++;
      step();
      chk($sformatf("gate_dov_i%0d", i), data_out_valid, en ? 1 : 0);
      chk($sformatf("gate_dclk_i%0d", i), data_clk, exp_dclk ? 1 : 0);
      chk($sformatf("gate_out_i%0d", i), data_out, (cnt == 0) ? 0 : imp_exp[cnt-1]);
    end
    chk("gate_underflow", underflow, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cic_interp.md
CIC_INTERP -- requirements
Module: cic_interp

Interface
REQ-001 SHALL have parameter DATA_WIDTH_I, default 16, signed input sample width.
REQ-002 SHALL have parameter DATA_WIDTH_O, default 12, signed output sample width.
REQ-003 SHALL have parameter REGISTER_WIDTH, default 64, width of all comb and integrator registers.
REQ-004 SHALL have parameter INTERPOLATION_RATIO, default 8, output samples per input sample; power of two, >=2.
REQ-005 SHALL have parameter OUT_SHIFT, default 13, arithmetic right shift applied to the last integrator before output truncation.
REQ-006 SHALL have port clk, input, 1, single clock for all logic.
REQ-007 SHALL have port arst_n, input, 1, reset; synchronous to clk, active-low.
REQ-008 SHALL have port en, input, 1, high-rate clock enable; one output sample per en-high cycle.
REQ-009 SHALL have port data_in, input, DATA_WIDTH_I, signed low-rate input sample.
REQ-010 SHALL have port data_in_valid, input, 1, data_in holds a valid sample.
REQ-011 SHALL have port data_in_ready, output, 1, block accepts data_in this cycle.
REQ-012 SHALL have port data_out, output, DATA_WIDTH_O, signed high-rate output sample.
REQ-013 SHALL have port data_out_valid, output, 1, data_out updated this cycle.
REQ-014 SHALL have port data_clk, output, 1, one-cycle pulse marking each input-sample consume event.
REQ-015 SHALL have port underflow, output, 1, sticky flag: a consume event found no buffered sample.

Function
REQ-016 SHALL implement a 4-stage comb section at low rate, zero-stuffing by INTERPOLATION_RATIO, and a 4-stage integrator section at high rate.
REQ-017 SHALL keep a phase counter 0..INTERPOLATION_RATIO-1, advancing only on en-high cycles and wrapping from RATIO-1 to 0.
REQ-018 SHALL define a consume event as a cycle with en high and phase counter 0.
REQ-019 SHALL hold one input sample in a single-entry buffer; a transfer occurs when data_in_valid and data_in_ready are both high.
REQ-020 SHALL drive data_in_ready = buffer empty OR consume event this cycle; transfer and consume in the same cycle replace the buffer contents, which stay full.
REQ-021 SHALL, on a consume event, feed the buffered sample (sign-extended to REGISTER_WIDTH) into the comb section and mark the buffer empty unless refilled that cycle.
REQ-022 SHALL, on a consume event with the buffer empty, feed zero into the comb section and set underflow high until reset.
REQ-023 SHALL compute the combs combinationally on a consume event: c1 = x - x_d, ck = c(k-1) - c(k-1)_d for k = 2..4; the delay registers update only on consume events.
REQ-024 SHALL, on each en-high cycle, register zs <= c4 if consume event, else 0.
REQ-025 SHALL, on each en-high cycle, update I1 <= I1 + zs, I2 <= I2 + I1, I3 <= I3 + I2, I4 <= I4 + I3 using pre-update values.
REQ-026 SHALL use two's-complement wrap-around modulo 2^REGISTER_WIDTH in all adders and subtractors, with no saturation.
REQ-027 SHALL drive data_out = low DATA_WIDTH_O bits of (I4 >>> OUT_SHIFT), a truncation with no rounding or saturation.
REQ-028 SHALL register data_out_valid <= en and data_clk <= consume event.
REQ-029 SHALL set the latency from a consume edge to the first data_out reflecting that sample at 4 en-high cycles.
REQ-030 SHALL freeze all state while en is low, including counter, combs, zs, integrators and underflow; the input handshake still fills an empty buffer.
REQ-031 SHALL give a DC gain of INTERPOLATION_RATIO^3 (512 at default) before OUT_SHIFT.

Reset
REQ-032 SHALL, with arst_n low at a clk edge, clear the phase counter, buffer valid, all comb delay registers, zs, I1..I4, data_out_valid, data_clk and underflow.
REQ-033 SHALL drive data_out = 0 and data_in_ready = 1 immediately after reset.
REQ-034 SHALL make reset take priority over en and over any handshake in the same cycle, including mid-period; no sample is retained.

Verification
REQ-035 SHALL pass impulse: OUT_SHIFT=0, en held high, x = 1 then zeros every consume -> I4 first nonzero = 1 exactly 4 en cycles after the first consume edge; no underflow.
REQ-036 SHALL pass DC: constant x = 1000 at defaults, en held high -> data_out settles at 62 (512000 >>> 13) on every output sample.
REQ-037 SHALL pass full scale: constant x = 32767 at defaults -> data_out settles at 2047 with no wrap.
REQ-038 SHALL pass underflow: data_in_valid low at a consume event -> underflow = 1 from the next cycle and it persists; data_clk still pulses.
REQ-039 SHALL pass en gating: en toggling 1010... -> data_out_valid and data_clk follow en by one cycle; output sequence equals the en-continuous sequence.
REQ-040 SHALL pass reset mid-period: arst_n low at phase counter 5 with nonzero integrators -> next cycle all state is 0, data_in_ready = 1, data_out = 0, underflow = 0.
